// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection and a return-address stack.
//
// The PC and the return-address stack (RAS) update on the falling edge of
// clock. clear is an asynchronous, active-high reset. The next PC is chosen
// with this priority: stall, ret, jump_reg, jump, branch_taken, then the
// sequential PC. The RAS is a circular buffer. A push to a full stack
// overwrites the oldest entry and sets the sticky ras_overflow flag.
//
// Optional build macro PC_ALIGN_CHECK_EN:
//   When defined, any selected next PC whose low two bits are nonzero is
//   loaded with those bits cleared. The registered output misaligned pulses
//   for that cycle.
//   When undefined, the misaligned port does not exist and the next PC is
//   loaded unmodified.

module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00400000,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [WIDTH-1:0]             branch_offset,
  input  logic                         jump,
  input  logic [WIDTH-7:0]             jump_index,
  input  logic                         jump_reg,
  input  logic [WIDTH-1:0]             reg_target,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus4,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                         misaligned
`endif
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Source of the next PC. HOLD is used while stalled.
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_REG,
    SRC_RAS,
    SRC_HOLD
  } pc_src_t;

  // Stack storage. top_ptr always points at the most recent entry.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;

  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;

  pc_src_t          pc_src;
  logic             do_pop;
  logic             do_push;
  logic             underflow_next;
  logic [WIDTH-1:0] pc_sel;
  logic [WIDTH-1:0] pc_next;

  logic [PTR_W-1:0] ptr_next;
  logic [CNT_W-1:0] count_next;
  logic             ras_we;
  logic [PTR_W-1:0] ras_wr_ptr;
  logic             overflow_set;

`ifdef PC_ALIGN_CHECK_EN
  logic             misaligned_next;
`endif

  // Target arithmetic. All sums wrap silently at WIDTH bits.
  always_comb begin
    pc_plus4      = pc + WIDTH'(4);
    branch_target = pc_plus4 + (branch_offset << 2);
    jump_target   = {pc_plus4[WIDTH-1 -: 4], jump_index, 2'b00};
    ras_top       = ras_mem[top_ptr];
    ras_empty     = (ras_count == '0);
    ras_full      = (ras_count == CNT_W'(RAS_DEPTH));
  end

  // Select the next-PC source and decide the stack operation.
  always_comb begin
    // NOTE: assign every always_comb output a default first. Without a
    // default, a path that skips an assignment infers a latch.
    pc_src         = SRC_SEQ;
    do_pop         = 1'b0;
    do_push        = 1'b0;
    underflow_next = 1'b0;
    if (stall) begin
      pc_src = SRC_HOLD;
    end else begin
      if (ret) begin
        if (!ras_empty) begin
          pc_src = SRC_RAS;
          do_pop = 1'b1;
        end else begin
          pc_src         = SRC_REG;
          underflow_next = 1'b1;
        end
      end else if (jump_reg) begin
        pc_src = SRC_REG;
      end else if (jump) begin
        pc_src = SRC_JUMP;
      end else if (branch_taken) begin
        pc_src = SRC_BRANCH;
      end
      do_push = call;
    end
  end

  // Next-PC multiplexer, with optional forced word alignment.
  always_comb begin
    unique case (pc_src)
      SRC_BRANCH: pc_sel = branch_target;
      SRC_JUMP:   pc_sel = jump_target;
      SRC_REG:    pc_sel = reg_target;
      SRC_RAS:    pc_sel = ras_top;
      SRC_HOLD:   pc_sel = pc;
      default:    pc_sel = pc_plus4;
    endcase
`ifdef PC_ALIGN_CHECK_EN
    misaligned_next = (pc_src != SRC_HOLD) && (pc_sel[1:0] != 2'b00);
    pc_next         = {pc_sel[WIDTH-1:2], 2'b00};
`else
    pc_next         = pc_sel;
`endif
  end

  // Stack pointer, count and write-port control.
  always_comb begin
    ptr_next     = top_ptr;
    count_next   = ras_count;
    ras_we       = 1'b0;
    ras_wr_ptr   = top_ptr;
    overflow_set = 1'b0;
    unique case ({do_pop, do_push})
      2'b10: begin
        ptr_next   = top_ptr - PTR_W'(1);
        count_next = ras_count - CNT_W'(1);
      end
      2'b01: begin
        // Advancing the pointer on a full stack lands on the oldest entry,
        // so the circular overwrite needs no special case here.
        ptr_next     = top_ptr + PTR_W'(1);
        ras_wr_ptr   = top_ptr + PTR_W'(1);
        ras_we       = 1'b1;
        count_next   = ras_full ? ras_count : ras_count + CNT_W'(1);
        overflow_set = ras_full;
      end
      2'b11: begin
        // Pop the old top, then write pc_plus4 into the slot just freed.
        ras_we = 1'b1;
      end
      default: ;
    endcase
  end

  // PC, flags and stack state. Updates on the falling edge; clear is asynchronous.
  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      pc            <= RESET_VECTOR;
      top_ptr       <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      // NOTE: the stack entries are cleared by reset so that a pop after
      // reset reads zero. That reset forces the storage into flops; it
      // cannot map to a RAM macro.
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
`ifdef PC_ALIGN_CHECK_EN
      misaligned    <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop
      // then samples values from before the edge, and no flop sees a value
      // written earlier in the same edge.
      pc            <= pc_next;
      top_ptr       <= ptr_next;
      ras_count     <= count_next;
      ras_overflow  <= ras_overflow | overflow_set;
      ras_underflow <= underflow_next;
      if (ras_we) begin
        ras_mem[ras_wr_ptr] <= pc_plus4;
      end
`ifdef PC_ALIGN_CHECK_EN
      misaligned    <= misaligned_next;
`endif
    end
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle datapath; next generation of the plain PC register.
- Owns the PC and computes the next PC: sequential, conditional branch, absolute jump, register jump.
- Adds a small return-address stack (RAS) that pushes on call and pops on return.
- Feeds instruction memory and the PC+4 link path.

Parameters:
WIDTH, 32, PC and address width (>= 8)
RESET_VECTOR, 32'h00400000, PC value loaded on clear
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
clock  input  1  system clock; all state updates on the falling edge
clear  input  1  asynchronous active-high reset
stall  input  1  hold PC and RAS this cycle
branch_taken  input  1  take conditional branch
branch_offset  input  WIDTH  sign-extended word offset
jump  input  1  absolute jump
jump_index  input  WIDTH-6  jump word index
jump_reg  input  1  jump to reg_target
reg_target  input  WIDTH  register jump target
call  input  1  push pc_plus4 onto RAS (qualifies jump/jump_reg)
ret  input  1  pop RAS and jump to popped address
pc  output  WIDTH  current PC (registered)
pc_plus4  output  WIDTH  pc+4 (combinational from pc)
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries (registered)
ras_overflow  output  1  sticky: push occurred while full
ras_underflow  output  1  one-cycle pulse: ret while empty

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clock and clear.
- Reset values while clear is high: pc=RESET_VECTOR, ras_count=0, all RAS entries 0, ras_overflow=0, ras_underflow=0.
- Clear asserted mid-cycle overrides everything immediately. First update after release happens on the next falling edge.
- Arithmetic, all mod 2^WIDTH with silent wrap:
  - pc_plus4 = pc+4.
  - Branch target = pc_plus4 + (branch_offset<<2).
  - Jump target = {pc_plus4[WIDTH-1:WIDTH-4], jump_index, 2'b00}.
- Next-PC priority, evaluated each falling edge (highest first):
  - stall: pc, RAS, ras_count unchanged; ras_underflow driven 0; call/ret ignored.
  - ret: if ras_count>0, pc=top entry and pop. If empty, pc=reg_target, count stays 0, ras_underflow=1 for that cycle.
  - jump_reg: pc=reg_target.
  - jump: pc=jump target.
  - branch_taken: pc=branch target.
  - otherwise: pc=pc_plus4.
- Latency: one falling edge from inputs to new pc.
- RAS push: on call, not stalled and ret low, write pc_plus4 to top, ras_count+1.
- Push when full: circular overwrite of the oldest entry. ras_count stays RAS_DEPTH; ras_overflow set and held until clear.
- call and ret together: pop supplies next pc (old top). The freed slot is then written with pc_plus4, so net ras_count is unchanged. If the RAS was empty: underflow pulse, pc=reg_target, pc_plus4 pushed, count=1.
- call without jump/jump_reg/ret still pushes; PC follows normal priority.
- ras_underflow is registered and deasserts on the next non-underflow edge.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: adds output misaligned (1 bit, reset 0).
  - Any selected next PC with bits[1:0]!=0 (reg_target, RAS pop) is loaded with bits[1:0] forced to 00.
  - misaligned pulses 1 for that cycle.
- Undefined: no misaligned port; next PC loaded unmodified.

Test Plan:
- Reset and sequence: clear high, then low, no controls for 3 falling edges -> pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C; ras_count=0.
- Branch and wrap: at pc=0x00400010, branch_taken with offset 0xFFFFFFFC -> pc=0x00400004. Set RESET_VECTOR=0xFFFFFFFC; one plain edge after clear -> pc=0x00000000.
- Call/return: at pc=0x00400020, jump+call with jump_index=0x0100040 -> pc=0x00400100, ras_count=1. Next, ret -> pc=0x00400024, ras_count=0.
- RAS overflow and underflow (RAS_DEPTH=4): five calls -> ras_count=4, ras_overflow=1. Four rets return the last four pushed addresses in LIFO order. Fifth ret with reg_target=0x00400800 -> pc=0x00400800, one-cycle ras_underflow.
- Stall and async clear: stall high with jump+call asserted -> pc and ras_count unchanged. Assert clear between edges -> pc=0x00400000 and ras_overflow=0 immediately, before the next edge.
- With PC_ALIGN_CHECK_EN: jump_reg to 0x00400013 -> pc=0x00400010, misaligned pulses 1 for one cycle.
